// File: rtl/vc_arbiter_ctrl.sv
// Two-VC transmit scheduler: weighted VC0/VC1 pop arbitration with a one-cycle
// pop-to-push pipeline that routes each word to D0/D1 by its MSB.
module vc_arbiter_ctrl #(
    parameter int DATA_W   = 6,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    input  logic                fifo_error,
    input  logic                d0_almost_full,
    input  logic                d1_almost_full,
    output logic                vc0_rd_en,
    output logic                vc1_rd_en,
    output logic                d0_wr_en,
    output logic                d1_wr_en,
    output logic [DATA_W-1:0]   d_data,
    output logic [WEIGHT_W-1:0] active_weight,
    output logic [2:0]          state,
    output logic                idle,
    output logic                error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

    state_e              state_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic [WEIGHT_W-1:0] grant_q;
    logic [WEIGHT_W-1:0] grant_d;
    logic                inflight_q;
    logic                src_q;
    logic                pop_ok;
    logic                pop0;
    logic                pop1;
    logic [DATA_W-1:0]   rdata;

    // The destination of a popped word is unknown until it returns, so both
    // destinations must have slack before anything is popped.
    always_comb begin
        pop_ok = (state_q == ST_ACTIVE) && !d0_almost_full && !d1_almost_full
                 && !init && !fifo_error;
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (pop_ok) begin
            if (!vc0_empty && (vc1_empty || grant_q < weight_q)) begin
                pop0 = 1'b1;
            end else if (!vc1_empty) begin
                pop1 = 1'b1;
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        if (pop1) begin
            grant_d = '0;
        end else if (pop0) begin
            if (vc1_empty) begin
                grant_d = '0;
            end else if (grant_q >= weight_q) begin
                grant_d = weight_q;
            end else begin
                grant_d = grant_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            weight_q   <= ONE;
            grant_q    <= '0;
            inflight_q <= 1'b0;
            src_q      <= 1'b0;
        end else begin
            inflight_q <= pop0 | pop1;
            src_q      <= pop1;
            grant_q    <= grant_d;
            if (state_q == ST_INIT) begin
                weight_q <= (cfg_weight == '0) ? ONE : cfg_weight;
            end
            if (fifo_error || state_q == ST_ERROR) begin
                state_q <= ST_ERROR;
            end else if (state_q == ST_RESET || init) begin
                state_q <= ST_INIT;
            end else begin
                case (state_q)
                    ST_INIT:   state_q <= ST_IDLE;
                    ST_IDLE:   if (!vc0_empty || !vc1_empty) state_q <= ST_ACTIVE;
                    ST_ACTIVE: if (vc0_empty && vc1_empty && !inflight_q) state_q <= ST_IDLE;
                    default:   state_q <= state_q;
                endcase
            end
        end
    end

    // Second stage: the word popped last cycle is on the VC read bus now.
    assign rdata     = src_q ? vc1_data : vc0_data;
    assign d_data    = inflight_q ? rdata : '0;
    assign d0_wr_en  = inflight_q & ~rdata[DATA_W-1];
    assign d1_wr_en  = inflight_q &  rdata[DATA_W-1];

    assign vc0_rd_en     = pop0;
    assign vc1_rd_en     = pop1;
    assign active_weight = weight_q;
    assign state         = state_q;
    assign idle          = (state_q == ST_IDLE);
    assign error_out     = (state_q == ST_ERROR);

endmodule
